// File: rtl/arb_pkg.sv
// Shared arbiter types and helpers used by the arbiter family of blocks.
package arb_pkg;

  // Helpers work on a fixed maximum width; callers zero-extend and truncate.
  localparam int ARB_MAX_W = 64;
  localparam int ARB_IDX_W = $clog2(ARB_MAX_W);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Isolate the lowest set bit (highest-priority requester).
  function automatic logic [ARB_MAX_W-1:0] lowest_bit(input logic [ARB_MAX_W-1:0] r);
    return r & ~(r - ARB_MAX_W'(1));
  endfunction

  // Binary index of a one-hot vector; zero for an all-zero vector.
  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_W-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_W; i++) begin
      if (oh[i]) idx = idx | ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_fixed_prio.sv
// Combinational fixed-priority arbiter: bit 0 wins.
module arb_fixed_prio
  import arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] gnt_o
);

  // One-hot pick of the lowest-index active request.
  always_comb begin
    gnt_o = WIDTH'(lowest_bit(ARB_MAX_W'(req_i)));
  end

endmodule

// File: rtl/arb_grant_lock.sv
// Grant-holding stage: locks the arbiter pick into a registered ownership
// window that ends on done, owner abandon, or hold timeout.
module arb_grant_lock
  import arb_pkg::*;
#(
  parameter int REQ_WIDTH = 8,
  parameter int IDX_WIDTH = $clog2(REQ_WIDTH),
  parameter int MAX_HOLD  = 16,
  parameter int CNT_WIDTH = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQ_WIDTH-1:0] req,
  input  logic                 done,
  output logic [REQ_WIDTH-1:0] gnt,
  output logic                 gnt_valid,
  output logic [IDX_WIDTH-1:0] gnt_idx,
  output logic                 busy,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] HOLD_MAX = CNT_WIDTH'(MAX_HOLD);

  state_e               state_q;
  logic [REQ_WIDTH-1:0] gnt_q;
  logic [IDX_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 timeout_q;
  logic [REQ_WIDTH-1:0] pick;
  logic                 owner_req;
  logic                 expired;

  arb_fixed_prio #(.WIDTH(REQ_WIDTH)) u_arb (
    .req_i (req),
    .gnt_o (pick)
  );

  // Owner still requesting, and hold window used up.
  always_comb begin
    owner_req = |(req & gnt_q);
    expired   = (cnt_q == HOLD_MAX);
  end

  // Ownership FSM; every release drops to IDLE, which is the one-cycle bubble
  // in which the next owner is picked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q   <= pick;
            idx_q   <= IDX_WIDTH'(onehot_to_idx(ARB_MAX_W'(pick)));
            cnt_q   <= CNT_WIDTH'(1);
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (done || !owner_req || expired) begin
            gnt_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            // done and abandon take precedence over expiry
            timeout_q <= !done && owner_req;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_idx   = idx_q;
  assign busy      = (state_q == GRANT);
  assign timeout   = timeout_q;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_valid:  assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == |gnt);
  a_busy:   assert property (@(posedge clk) disable iff (!rst_n) busy == gnt_valid);

endmodule

// File: tb/tb_arb_grant_lock.sv
// Directed bench for arb_grant_lock (REQ_WIDTH=8, MAX_HOLD=16).
module tb_arb_grant_lock;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  // {gnt, gnt_idx, gnt_valid, busy, timeout}
  logic [13:0] obs;
  assign obs = {gnt, gnt_idx, gnt_valid, busy, timeout};

  arb_grant_lock #(.REQ_WIDTH(8), .MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; done = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 14'b0) begin n_err++; $display("FAIL reset_state: got %h want %h", obs, 14'b0); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    // done while idle is ignored
    done = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 14'b0) begin n_err++; $display("FAIL idle_done: got %h want %h", obs, 14'b0); end
    done = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req = 8'h04;
    tick();
    n_cmp++;
    if (obs !== {8'h04, 3'd2, 1'b1, 1'b1, 1'b0}) begin n_err++; $display("FAIL single_grant: got %h want %h", obs, {8'h04, 3'd2, 3'b110}); end
    tick();
    tick();
    n_cmp++;
    if (obs !== {8'h04, 3'd2, 1'b1, 1'b1, 1'b0}) begin n_err++; $display("FAIL single_hold3: got %h want %h", obs, {8'h04, 3'd2, 3'b110}); end
    done = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 14'b0) begin n_err++; $display("FAIL single_release: got %h want %h", obs, 14'b0); end
    done = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_no_preempt();
    req = 8'h20;
    tick();
    n_cmp++;
    if (obs !== {8'h20, 3'd5, 3'b110}) begin n_err++; $display("FAIL npre_grant: got %h want %h", obs, {8'h20, 3'd5, 3'b110}); end
    req = 8'h21;
    tick();
    n_cmp++;
    if (obs !== {8'h20, 3'd5, 3'b110}) begin n_err++; $display("FAIL npre_hold: got %h want %h", obs, {8'h20, 3'd5, 3'b110}); end
    done = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 14'b0) begin n_err++; $display("FAIL npre_bubble: got %h want %h", obs, 14'b0); end
    done = 1'b0;
    tick();
    n_cmp++;
    if (obs !== {8'h01, 3'd0, 3'b110}) begin n_err++; $display("FAIL npre_next: got %h want %h", obs, {8'h01, 3'd0, 3'b110}); end
    req = '0;
    tick();
    n_cmp++;
    if (obs !== 14'b0) begin n_err++; $display("FAIL npre_drop: got %h want %h", obs, 14'b0); end
    tick();
  endtask

  task automatic test_timeout();
    req = 8'h80;
    tick();
    for (int k = 2; k <= 16; k++) begin
      tick();
      n_cmp++;
      if (obs !== {8'h80, 3'd7, 3'b110}) begin n_err++; $display("FAIL tmo_hold[%0d]: got %h want %h", k, obs, {8'h80, 3'd7, 3'b110}); end
    end
    tick();
    n_cmp++;
    if (obs !== {8'h00, 3'd0, 3'b001}) begin n_err++; $display("FAIL tmo_pulse: got %h want %h", obs, {8'h00, 3'd0, 3'b001}); end
    tick();
    n_cmp++;
    if (obs !== {8'h80, 3'd7, 3'b110}) begin n_err++; $display("FAIL tmo_regrant: got %h want %h", obs, {8'h80, 3'd7, 3'b110}); end
    req = '0;
    tick();
    n_cmp++;
    if (obs !== 14'b0) begin n_err++; $display("FAIL tmo_drop: got %h want %h", obs, 14'b0); end
    tick();
  endtask

  task automatic test_abandon();
    req = 8'h08;
    tick();
    n_cmp++;
    if (obs !== {8'h08, 3'd3, 3'b110}) begin n_err++; $display("FAIL abn_grant: got %h want %h", obs, {8'h08, 3'd3, 3'b110}); end
    repeat (3) tick();
    n_cmp++;
    if (obs !== {8'h08, 3'd3, 3'b110}) begin n_err++; $display("FAIL abn_hold4: got %h want %h", obs, {8'h08, 3'd3, 3'b110}); end
    req = '0;
    tick();
    n_cmp++;
    if (obs !== 14'b0) begin n_err++; $display("FAIL abn_release: got %h want %h", obs, 14'b0); end
    tick();
  endtask

  task automatic test_done_at_expiry();
    req = 8'h02;
    tick();
    for (int k = 2; k <= 16; k++) tick();
    n_cmp++;
    if (obs !== {8'h02, 3'd1, 3'b110}) begin n_err++; $display("FAIL dex_last: got %h want %h", obs, {8'h02, 3'd1, 3'b110}); end
    done = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 14'b0) begin n_err++; $display("FAIL dex_release: got %h want %h", obs, 14'b0); end
    done = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_async_reset();
    req = 8'h02;
    tick();
    n_cmp++;
    if (obs !== {8'h02, 3'd1, 3'b110}) begin n_err++; $display("FAIL ars_grant: got %h want %h", obs, {8'h02, 3'd1, 3'b110}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 14'b0) begin n_err++; $display("FAIL ars_clear: got %h want %h", obs, 14'b0); end
    req = 8'h06;
    @(negedge clk) rst_n = 1'b1;
    n_cmp++;
    if (obs !== 14'b0) begin n_err++; $display("FAIL ars_idle: got %h want %h", obs, 14'b0); end
    tick();
    n_cmp++;
    if (obs !== {8'h02, 3'd1, 3'b110}) begin n_err++; $display("FAIL ars_regrant: got %h want %h", obs, {8'h02, 3'd1, 3'b110}); end
    done = 1'b1;
    tick();
    done = 1'b0; req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_no_preempt();
    test_timeout();
    test_abandon();
    test_done_at_expiry();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
